// File: rtl/mem_dbus_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_dbus_ctrl : MEM-stage load/store controller driving a req/ack data bus |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module mem_dbus_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_mem_addr,
  input  logic [31:0] mem_reg2,
  input  logic [7:0]  mem_aluop,
  input  logic        flush,
  input  logic [5:0]  stall,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o,
  output logic        align_err_o,
  output logic        bus_err_o,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_wdata_o,
  output logic [3:0]  dbus_sel_o,
  input  logic        dbus_ack_i,
  input  logic [31:0] dbus_rdata_i
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
  localparam logic       NO_STOP    = 1'b0;
  localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, DONE = 2'd2} state_t;

  state_t      state, state_next;
  logic        is_byte, is_half, is_word, is_store, memop, misaligned;
  logic        issue, ack_done, timeout_hit;
  logic [3:0]  sel_next;
  logic [31:0] wdata_next;
  logic [7:0]  wait_cnt;
  logic        kill;
  logic [31:0] result;
  logic [7:0]  op_q;
  logic [1:0]  off_q;
  logic        store_q;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;
  logic        unused_stall_bits;

  assign unused_stall_bits = ^{stall[5], stall[3:0]};

  always_comb begin
    is_byte  = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    is_store = 1'b0;
    case (mem_aluop)
      EXE_LB_OP, EXE_LBU_OP: is_byte = 1'b1;
      EXE_LH_OP, EXE_LHU_OP: is_half = 1'b1;
      EXE_LW_OP:             is_word = 1'b1;
      EXE_SB_OP: begin is_byte = 1'b1; is_store = 1'b1; end
      EXE_SH_OP: begin is_half = 1'b1; is_store = 1'b1; end
      EXE_SW_OP: begin is_word = 1'b1; is_store = 1'b1; end
      default: ;
    endcase
  end

  assign memop      = is_byte | is_half | is_word;
  assign misaligned = (is_half && mem_mem_addr[0]) || (is_word && (mem_mem_addr[1:0] != 2'b00));

  // Big-endian lanes: byte offset 0 lives in bits [31:24].
  always_comb begin
    sel_next   = 4'b1111;
    wdata_next = mem_reg2;
    if (is_byte) begin
      sel_next   = 4'b1000 >> mem_mem_addr[1:0];
      wdata_next = {4{mem_reg2[7:0]}};
    end else if (is_half) begin
      sel_next   = mem_mem_addr[1] ? 4'b0011 : 4'b1100;
      wdata_next = {2{mem_reg2[15:0]}};
    end
  end

  always_comb begin
    case (off_q)
      2'd0:    lane_byte = dbus_rdata_i[31:24];
      2'd1:    lane_byte = dbus_rdata_i[23:16];
      2'd2:    lane_byte = dbus_rdata_i[15:8];
      default: lane_byte = dbus_rdata_i[7:0];
    endcase
    lane_half = off_q[1] ? dbus_rdata_i[15:0] : dbus_rdata_i[31:16];
    case (op_q)
      EXE_LB_OP:  load_data = {{24{lane_byte[7]}}, lane_byte};
      EXE_LBU_OP: load_data = {24'd0, lane_byte};
      EXE_LH_OP:  load_data = {{16{lane_half[15]}}, lane_half};
      EXE_LHU_OP: load_data = {16'd0, lane_half};
      default:    load_data = dbus_rdata_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next  = state;
    issue       = 1'b0;
    ack_done    = 1'b0;
    timeout_hit = 1'b0;
    stallreq_o  = 1'b0;
    align_err_o = 1'b0;
    wd_o        = mem_wd;
    wreg_o      = mem_wreg;
    wdata_o     = mem_wdata;
    case (state)
      IDLE: begin
        if (flush || memop) wreg_o = 1'b0;
        if (memop && !flush) begin
          if (misaligned) begin
            align_err_o = 1'b1;
          end else begin
            stallreq_o = 1'b1;
            issue      = 1'b1;
            state_next = BUS;
          end
        end
      end
      BUS: begin
        stallreq_o = 1'b1;
        wreg_o     = 1'b0;
        // A same-cycle ack wins over the timeout.
        if (dbus_ack_i) begin
          ack_done   = 1'b1;
          state_next = (kill || flush) ? IDLE : DONE;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end
      end
      DONE: begin
        wdata_o = result;
        if (store_q) wreg_o = 1'b0;
        if (stall[4] == NO_STOP) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (!rst) stallreq_o = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt     <= 8'd0;
      kill         <= 1'b0;
      result       <= 32'd0;
      op_q         <= 8'd0;
      off_q        <= 2'd0;
      store_q      <= 1'b0;
      bus_err_o    <= 1'b0;
      dbus_req_o   <= 1'b0;
      dbus_we_o    <= 1'b0;
      dbus_addr_o  <= 32'd0;
      dbus_wdata_o <= 32'd0;
      dbus_sel_o   <= 4'd0;
    end else begin
      bus_err_o <= timeout_hit;
      if (issue) begin
        dbus_req_o   <= 1'b1;
        dbus_we_o    <= is_store;
        dbus_addr_o  <= {mem_mem_addr[31:2], 2'b00};
        dbus_sel_o   <= sel_next;
        dbus_wdata_o <= wdata_next;
        op_q         <= mem_aluop;
        off_q        <= mem_mem_addr[1:0];
        store_q      <= is_store;
        wait_cnt     <= 8'd0;
        kill         <= 1'b0;
      end else if (state == BUS) begin
        if (ack_done || timeout_hit) begin
          dbus_req_o <= 1'b0;
          dbus_we_o  <= 1'b0;
          kill       <= 1'b0;
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
          if (flush) kill <= 1'b1;
        end
        if (ack_done && !(kill || flush)) result <= load_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_dbus_ctrl.sv
`default_nettype none
// Self-checking bench for mem_dbus_ctrl: cycle-level reference model plus directed literal checks.
module tb_mem_dbus_ctrl;

  localparam int TMO = 4;
  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;
  localparam logic [7:0] OP_NOP = 8'b0010_0000;

  logic        clk, rst;
  logic [4:0]  mem_wd;
  logic        mem_wreg, flush, dbus_ack_i;
  logic [31:0] mem_wdata, mem_mem_addr, mem_reg2, dbus_rdata_i;
  logic [7:0]  mem_aluop;
  logic [5:0]  stall;
  logic [4:0]  wd_o;
  logic        wreg_o, stallreq_o, align_err_o, bus_err_o, dbus_req_o, dbus_we_o;
  logic [31:0] wdata_o, dbus_addr_o, dbus_wdata_o;
  logic [3:0]  dbus_sel_o;

  int errors = 0;
  int checks = 0;

  mem_dbus_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2), .mem_aluop(mem_aluop), .flush(flush),
    .stall(stall), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq_o(stallreq_o),
    .align_err_o(align_err_o), .bus_err_o(bus_err_o), .dbus_req_o(dbus_req_o),
    .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o), .dbus_wdata_o(dbus_wdata_o),
    .dbus_sel_o(dbus_sel_o), .dbus_ack_i(dbus_ack_i), .dbus_rdata_i(dbus_rdata_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int op_size(input logic [7:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_SW:         return 4;
      default:              return 0;
    endcase
  endfunction

  function automatic logic is_st(input logic [7:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [3:0] exp_sel(input logic [7:0] op, input logic [1:0] a);
    int s = op_size(op);
    if (s == 1) return 4'b1000 >> a;
    if (s == 2) return 4'b1100 >> a;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [7:0] op, input logic [31:0] r);
    int s = op_size(op);
    if (s == 1) return {4{r[7:0]}};
    if (s == 2) return {2{r[15:0]}};
    return r;
  endfunction

  function automatic logic [31:0] load_val(input logic [7:0] op, input logic [1:0] a, input logic [31:0] d);
    int s = op_size(op);
    int sh = 8 * (4 - s - int'(a));
    logic [31:0] v = d >> sh;
    if (s == 1) v = (op == OP_LB) ? {{24{v[7]}}, v[7:0]} : {24'd0, v[7:0]};
    if (s == 2) v = (op == OP_LH) ? {{16{v[15]}}, v[15:0]} : {16'd0, v[15:0]};
    return v;
  endfunction

  // Reference model: transaction in flight, completed result waiting, kill, wait count.
  logic        m_bus, m_done, m_kill, m_err;
  int          m_cnt;
  logic [7:0]  m_op;
  logic [31:0] m_addr, m_reg2, m_res;
  int          e_size;
  logic        e_idle, e_mem, e_mis, e_stall, e_align, e_wreg;

  always_comb begin
    e_idle  = !m_bus && !m_done;
    e_size  = op_size(mem_aluop);
    e_mem   = (e_size != 0);
    e_mis   = e_mem && ((mem_mem_addr[1:0] & 2'(e_size - 1)) != 2'b00);
    e_stall = m_bus || (e_idle && e_mem && !e_mis && !flush);
    e_align = e_idle && e_mem && e_mis && !flush;
    e_wreg  = m_bus ? 1'b0 : m_done ? (is_st(m_op) ? 1'b0 : mem_wreg) : ((e_mem || flush) ? 1'b0 : mem_wreg);
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_bus <= 1'b0; m_done <= 1'b0; m_kill <= 1'b0; m_err <= 1'b0; m_cnt <= 0;
      m_op <= 8'd0; m_addr <= 32'd0; m_reg2 <= 32'd0; m_res <= 32'd0;
    end else begin
      m_err <= 1'b0;
      if (m_bus) begin
        if (dbus_ack_i) begin
          m_bus  <= 1'b0;
          m_kill <= 1'b0;
          if (!(m_kill || flush)) begin
            m_done <= 1'b1;
            m_res  <= load_val(m_op, m_addr[1:0], dbus_rdata_i);
          end
        end else if (m_cnt + 1 == TMO) begin
          m_bus <= 1'b0; m_kill <= 1'b0; m_err <= 1'b1;
        end else begin
          m_cnt <= m_cnt + 1;
          if (flush) m_kill <= 1'b1;
        end
      end else if (m_done) begin
        if (!stall[4]) m_done <= 1'b0;
      end else if (e_mem && !e_mis && !flush) begin
        m_bus <= 1'b1; m_cnt <= 0; m_kill <= 1'b0;
        m_op <= mem_aluop; m_addr <= mem_mem_addr; m_reg2 <= mem_reg2;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("req", dbus_req_o, m_bus);
      chk("stallreq", stallreq_o, e_stall);
      chk("align_err", align_err_o, e_align);
      chk("bus_err", bus_err_o, m_err);
      chk("wd", wd_o, mem_wd);
      chk("wreg", wreg_o, e_wreg);
      if (m_bus) begin
        chk("addr", dbus_addr_o, {m_addr[31:2], 2'b00});
        chk("sel", dbus_sel_o, exp_sel(m_op, m_addr[1:0]));
        chk("we", dbus_we_o, is_st(m_op));
        if (is_st(m_op)) chk("bus_wdata", dbus_wdata_o, exp_wdata(m_op, m_reg2));
      end
      if (m_done && !is_st(m_op)) chk("load_result", wdata_o, m_res);
      else if (e_idle) chk("pass_wdata", wdata_o, mem_wdata);
    end else begin
      chk("rst_req", dbus_req_o, 1'b0);
      chk("rst_stallreq", stallreq_o, 1'b0);
      chk("rst_bus_err", bus_err_o, 1'b0);
      chk("rst_sel", dbus_sel_o, 4'd0);
    end
  end

  int          n_stall, n_req, n_err;
  logic        saw_wreg, obs_we, last_wreg;
  logic [3:0]  obs_sel;
  logic [31:0] obs_wdata, last_wdata;

  task automatic mem_txn(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] r2,
                         input logic [31:0] rdata, input int ack_at, input int flush_at,
                         input int hold, input int last);
    mem_aluop = op; mem_mem_addr = addr; mem_reg2 = r2;
    mem_wd = 5'd9; mem_wreg = 1'b1; mem_wdata = 32'h0;
    n_stall = 0; n_req = 0; n_err = 0; saw_wreg = 1'b0;
    obs_sel = 4'd0; obs_we = 1'b0; obs_wdata = 32'd0;
    for (int c = 0; c <= last; c++) begin
      dbus_ack_i   = (c == ack_at);
      dbus_rdata_i = (c == ack_at) ? rdata : 32'h0;
      flush        = (c == flush_at);
      stall        = (ack_at >= 0 && c > ack_at && c <= ack_at + hold) ? 6'b010000 : 6'b0;
      @(negedge clk);
      if (stallreq_o) n_stall++;
      if (bus_err_o) n_err++;
      if (wreg_o) saw_wreg = 1'b1;
      if (dbus_req_o) begin
        n_req++; obs_sel = dbus_sel_o; obs_we = dbus_we_o; obs_wdata = dbus_wdata_o;
      end
      if (c == last) begin last_wdata = wdata_o; last_wreg = wreg_o; end
      @(posedge clk); #2;
    end
    mem_aluop = OP_NOP; dbus_ack_i = 1'b0; flush = 1'b0; stall = 6'd0; mem_wreg = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus_err_o) n_err++;
      @(posedge clk); #2;
    end
  endtask

  initial begin
    rst = 1'b0; mem_wd = 5'd0; mem_wreg = 1'b0; mem_wdata = 32'd0; mem_mem_addr = 32'd0;
    mem_reg2 = 32'd0; mem_aluop = OP_NOP; flush = 1'b0; stall = 6'd0;
    dbus_ack_i = 1'b0; dbus_rdata_i = 32'd0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_req", dbus_req_o, 1'b0);
    chk("reset_sel", dbus_sel_o, 4'd0);
    chk("reset_addr", dbus_addr_o, 32'd0);
    chk("reset_bus_err", bus_err_o, 1'b0);
    chk("reset_stallreq", stallreq_o, 1'b0);
    rst = 1'b1;
    @(posedge clk); #2;

    // Non-memory pass-through, with a stray ack that must be ignored.
    mem_wd = 5'd7; mem_wreg = 1'b1; mem_wdata = 32'hDEADBEEF; dbus_ack_i = 1'b1;
    @(negedge clk);
    chk("pass_wd", wd_o, 32'd7);
    chk("pass_wreg", wreg_o, 1'b1);
    chk("pass_wdata_lit", wdata_o, 32'hDEADBEEF);
    chk("pass_stallreq", stallreq_o, 1'b0);
    @(posedge clk); #2;
    dbus_ack_i = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("flush_wreg", wreg_o, 1'b0);
    @(posedge clk); #2;
    flush = 1'b0;

    mem_txn(OP_LB, 32'h103, 32'h0, 32'h000000F0, 3, -1, 0, 4);
    chk("lb_sel", obs_sel, 4'b0001);
    chk("lb_stall_cycles", n_stall, 4);
    chk("lb_result", last_wdata, 32'hFFFFFFF0);

    mem_txn(OP_SH, 32'h202, 32'h1234ABCD, 32'h0, 1, -1, 2, 4);
    chk("sh_sel", obs_sel, 4'b0011);
    chk("sh_wdata", obs_wdata, 32'hABCDABCD);
    chk("sh_we", obs_we, 1'b1);
    chk("sh_wreg", last_wreg, 1'b0);

    mem_txn(OP_LBU, 32'h101, 32'h0, 32'h12F45678, 2, -1, 0, 3);
    chk("lbu_result", last_wdata, 32'h000000F4);
    mem_txn(OP_LH, 32'h200, 32'h0, 32'h80011234, 1, -1, 0, 2);
    chk("lh_result", last_wdata, 32'hFFFF8001);
    mem_txn(OP_SB, 32'h100, 32'h00000055, 32'h0, 2, -1, 0, 3);
    chk("sb_sel", obs_sel, 4'b1000);
    chk("sb_wdata", obs_wdata, 32'h55555555);

    mem_txn(OP_LW, 32'h100, 32'h0, 32'h0, -1, -1, 0, 4);
    chk("tmo_req_cycles", n_req, 4);
    chk("tmo_err_pulse", n_err, 1);

    mem_txn(OP_LW, 32'h108, 32'h0, 32'hCAFEF00D, 4, -1, 0, 5);
    chk("ackprio_err", n_err, 0);
    chk("ackprio_result", last_wdata, 32'hCAFEF00D);

    mem_txn(OP_LHU, 32'h206, 32'h0, 32'h0000BEEF, 3, 2, 0, 3);
    chk("kill_wreg_never", saw_wreg, 1'b0);
    chk("kill_req_cycles", n_req, 3);

    // Misaligned word: error flag only, no bus cycle.
    mem_aluop = OP_LW; mem_mem_addr = 32'h101; mem_wreg = 1'b1;
    @(negedge clk);
    chk("mis_align_err", align_err_o, 1'b1);
    chk("mis_stallreq", stallreq_o, 1'b0);
    chk("mis_wreg", wreg_o, 1'b0);
    @(posedge clk); #2;
    @(negedge clk);
    chk("mis_no_req", dbus_req_o, 1'b0);
    @(posedge clk); #2;
    mem_mem_addr = 32'h100; flush = 1'b1;
    @(negedge clk);
    chk("flush_no_issue", stallreq_o, 1'b0);
    @(posedge clk); #2;
    flush = 1'b0; mem_aluop = OP_NOP; mem_wreg = 1'b0;

    // Reset in the middle of a bus cycle.
    mem_aluop = OP_LW; mem_mem_addr = 32'h300;
    @(posedge clk); #2;
    @(negedge clk);
    chk("midrst_req_before", dbus_req_o, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk("midrst_req", dbus_req_o, 1'b0);
    chk("midrst_stallreq", stallreq_o, 1'b0);
    chk("midrst_addr", dbus_addr_o, 32'd0);
    mem_aluop = OP_NOP;
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    mem_txn(OP_LW, 32'h304, 32'h0, 32'h0BADF00D, 1, -1, 0, 2);
    chk("postrst_result", last_wdata, 32'h0BADF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_dbus_ctrl.md
MEM_DBUS_CTRL -- requirements
Module: mem_dbus_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of BUS-state cycles to wait for dbus_ack_i before aborting.
REQ-002 SHALL have port clk, input, 1, system clock; all state changes on posedge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset (0 = reset).
REQ-004 SHALL have ports mem_wd, 5, and mem_wreg, 1, both inputs; destination register and write-enable from the EX/MEM register.
REQ-005 SHALL have input ports mem_wdata, mem_mem_addr and mem_reg2, each 32; ALU result, effective address and store data.
REQ-006 SHALL have input port mem_aluop, 8, operation code; memory ops are `EXE_LB/LBU/LH/LHU/LW/SB/SH/SW_OP.
REQ-007 SHALL have ports flush, input, 1, pipeline flush; and stall, input, 6, controller stall vector (bit 4 = MEM/WB hold).
REQ-008 SHALL have outputs wd_o, 5; wreg_o, 1; wdata_o, 32; result toward MEM/WB.
REQ-009 SHALL have outputs stallreq_o, 1, pipeline hold request; align_err_o, 1, misaligned access; bus_err_o, 1, timeout pulse.
REQ-010 SHALL have outputs dbus_req_o, dbus_we_o, 1 each; dbus_addr_o, dbus_wdata_o, 32 each; dbus_sel_o, 4.
REQ-011 SHALL have inputs dbus_ack_i, 1, and dbus_rdata_i, 32.

Function
REQ-012 SHALL implement FSM states IDLE, BUS and DONE.
REQ-013 SHALL define memop = mem_aluop is one of the eight load/store codes.
REQ-014 SHALL define misaligned = halfword op with addr[0]=1, or word op with addr[1:0]!=0.
REQ-015 In IDLE with non-memop, SHALL pass mem_wd/mem_wreg/mem_wdata to the outputs combinationally, with stallreq_o=0.
REQ-016 In IDLE with memop, misaligned and no flush, SHALL set align_err_o=1 and wreg_o=0, issue no bus cycle, and stay in IDLE.
REQ-017 In IDLE with an aligned memop and flush=0, SHALL assert stallreq_o combinationally and, at the next edge, register the bus outputs and enter BUS.
REQ-018 Bus outputs SHALL be: dbus_addr_o = {addr[31:2],2'b00}; dbus_we_o = store; byte lanes big-endian (addr 00 -> sel 1000).
REQ-019 dbus_sel_o SHALL be: byte ops = one-hot lane; halfword = 1100 or 0011; word = 1111.
REQ-020 dbus_wdata_o SHALL be: SB = reg2[7:0] replicated x4; SH = reg2[15:0] replicated x2; SW = reg2.
REQ-021 In BUS, SHALL hold dbus_req_o=1 and all bus outputs stable, with stallreq_o=1, until dbus_ack_i=1.
REQ-022 On ack in BUS, SHALL drop dbus_req_o at that edge, capture the formatted load data into a 32-bit result register, and enter DONE.
REQ-023 Load formatting SHALL be: LB/LH sign-extend the selected lane; LBU/LHU zero-extend; LW uses the full word.
REQ-024 Stores SHALL drive wreg_o=0.
REQ-025 In DONE, SHALL drive stallreq_o=0, wdata_o = result register, and wd_o/wreg_o from the inputs.
REQ-026 DONE SHALL transition to IDLE on the first edge with stall[4]=`NoStop; otherwise it SHALL stay in DONE.
REQ-027 SHALL maintain an 8-bit wait counter, cleared on BUS entry and incremented each BUS cycle without ack.
REQ-028 When the wait counter reaches TIMEOUT, SHALL pulse bus_err_o for 1 cycle, drop dbus_req_o, clear the kill flag and enter IDLE.
REQ-029 flush in IDLE SHALL block any bus issue and force wreg_o=0.
REQ-030 flush in BUS SHALL set a kill flag while the transaction continues to ack or timeout.
REQ-031 On ack with kill=1, SHALL enter IDLE instead of DONE, discard the data, and keep wreg_o=0 while kill=1.
REQ-032 stallreq_o SHALL remain 1 during a killed BUS.
REQ-033 Ack arriving in the same cycle as a timeout SHALL take priority as a normal completion, with no bus_err_o.
REQ-034 dbus_ack_i outside BUS SHALL be ignored.

Reset
REQ-035 rst=0 SHALL immediately force state IDLE, counter 0, kill 0, result 0, and dbus_req_o/dbus_we_o 0.
REQ-036 rst=0 SHALL immediately force dbus_sel_o 0, dbus_addr_o/dbus_wdata_o 0, bus_err_o 0, and stallreq_o 0, including mid-transaction.
REQ-037 The block SHALL resume operation on the first posedge after rst returns to 1.

Verification
REQ-038 LB, addr 0x103, rdata 0x000000F0, ack after 3 cycles -> sel 0001, stallreq 4 cycles, wdata_o 0xFFFFFFF0.
REQ-039 SH, addr 0x202, reg2 0x1234ABCD -> sel 0011, wdata 0xABCDABCD, we=1, wreg_o=0 after ack.
REQ-040 LW, addr 0x101 -> align_err_o=1, no dbus_req_o, stallreq_o=0.
REQ-041 LW with ack never returned, TIMEOUT=4 -> bus_err_o 1-cycle pulse after 4 BUS cycles, then IDLE.
REQ-042 Flush in BUS cycle 2 of LHU, ack at cycle 3 -> returns to IDLE, wreg_o never 1.
REQ-043 rst=0 while in BUS -> dbus_req_o=0 asynchronously; the next LW after release completes normally.
